// File: rtl/irf_pkg.sv
// Shared constants and types for the integer register file write-back scheduler.
package irf_pkg;
  localparam int ADDR_W = 5;
  localparam int XLEN   = 32;
  localparam int NREGS  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/irf_wb_sched_if.sv
// Write-back request bus between the execute units (master) and the scheduler (slave).
interface irf_wb_sched_if #(
  parameter int N_SRC  = 3,
  parameter int ADDR_W = 5,
  parameter int XLEN   = 32
);
  logic [N_SRC-1:0]        wb_valid;
  logic [N_SRC-1:0]        wb_ready;
  logic [N_SRC*ADDR_W-1:0] wb_addr;
  logic [N_SRC*XLEN-1:0]   wb_data;

  modport master (output wb_valid, output wb_addr, output wb_data, input  wb_ready);
  modport slave  (input  wb_valid, input  wb_addr, input  wb_data, output wb_ready);
endinterface

// File: rtl/irf_wb_arb.sv
// N_SRC-wide write-back arbiter: fixed priority (lowest index wins) by default,
// round-robin with a rotating start pointer when IRF_WB_RR_EN is defined.
module irf_wb_arb #(
  parameter  int N_SRC = 3,
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
`ifdef IRF_WB_RR_EN
  input  logic             clk,
  input  logic             rst_n,
`endif
  input  logic [N_SRC-1:0] i_req,
  output logic [N_SRC-1:0] o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_any
);

`ifdef IRF_WB_RR_EN
  logic [IDX_W-1:0] r_ptr;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    int  j;
    logic found;
    o_gnt     = '0;
    o_gnt_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N_SRC) j = j - N_SRC;
      if (!found && i_req[j]) begin
        o_gnt[j]  = 1'b1;
        o_gnt_idx = IDX_W'(j);
        found     = 1'b1;
      end
    end
    o_gnt_any = found;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (o_gnt_any) begin
      r_ptr <= (o_gnt_idx == IDX_W'(N_SRC - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end
`else
  always_comb begin
    logic found;
    o_gnt     = '0;
    o_gnt_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && i_req[k]) begin
        o_gnt[k]  = 1'b1;
        o_gnt_idx = IDX_W'(k);
        found     = 1'b1;
      end
    end
    o_gnt_any = found;
  end
`endif

endmodule

// File: rtl/irf_wb_sched.sv
// IRF write-back scheduler and RAW/WAW scoreboard. Define IRF_WB_RR_EN for
// round-robin arbitration of the write-back sources (fixed priority otherwise).
module irf_wb_sched
  import irf_pkg::*;
#(
  parameter  int addr_width = ADDR_W,
  parameter  int XLEN       = irf_pkg::XLEN,
  parameter  int N_SRC      = 3,
  localparam int NR         = 1 << addr_width,
  localparam int IDX_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  irf_wb_sched_if.slave         wb,
  output logic                  o_rd_we,
  output logic [addr_width-1:0] o_rd_addr,
  output logic [XLEN-1:0]       o_rd_data,
  input  logic                  i_iss_valid,
  input  logic [addr_width-1:0] i_iss_rs1,
  input  logic [addr_width-1:0] i_iss_rs2,
  input  logic [addr_width-1:0] i_iss_rd,
  input  logic                  i_iss_rd_we,
  input  logic                  i_iss_fire,
  output logic                  o_iss_stall,
  output logic [NR-1:0]         o_busy_vec
);

  logic [N_SRC-1:0]      w_gnt;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_gnt_any;
  logic [addr_width-1:0] w_sel_addr;
  logic [XLEN-1:0]       w_sel_data;

  logic                  r_rd_we;
  logic [addr_width-1:0] r_rd_addr;
  logic [XLEN-1:0]       r_rd_data;
  logic [NR-1:0]         r_busy;
  logic [NR-1:0]         w_set;
  logic [NR-1:0]         w_clr;

  irf_wb_arb #(.N_SRC(N_SRC)) u_arb (
`ifdef IRF_WB_RR_EN
    .clk       (clk),
    .rst_n     (rst_n),
`endif
    .i_req     (wb.wb_valid),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_any (w_gnt_any)
  );

  // Grants are suppressed while reset is held so no unit sees a phantom handshake.
  assign wb.wb_ready = w_gnt & {N_SRC{rst_n}};
  assign w_sel_addr  = wb.wb_addr[int'(w_gnt_idx)*addr_width +: addr_width];
  assign w_sel_data  = wb.wb_data[int'(w_gnt_idx)*XLEN +: XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_we   <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else if (w_gnt_any) begin
      r_rd_we   <= (w_sel_addr != '0);
      r_rd_addr <= w_sel_addr;
      r_rd_data <= w_sel_data;
    end else begin
      r_rd_we   <= 1'b0;
    end
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_iss_fire && i_iss_rd_we && (i_iss_rd != '0)) w_set[i_iss_rd] = 1'b1;
    if (r_rd_we) w_clr[r_rd_addr] = 1'b1;
  end

  // NOTE: the scoreboard is plain flops, not a RAM, so it is reset outright; a stale busy bit would deadlock issue.
  // Set is OR-ed in after the clear so a same-cycle re-issue keeps the register busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= {(r_busy[NR-1:1] & ~w_clr[NR-1:1]) | w_set[NR-1:1], 1'b0};
    end
  end

  // No forwarding: a register being written this cycle still reads busy.
  assign o_iss_stall = i_iss_valid &
                       (r_busy[i_iss_rs1] | r_busy[i_iss_rs2] | (i_iss_rd_we & r_busy[i_iss_rd]));

  assign o_rd_we    = r_rd_we;
  assign o_rd_addr  = r_rd_addr;
  assign o_rd_data  = r_rd_data;
  assign o_busy_vec = r_busy;

  a_no_fire_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
    i_iss_fire |-> !o_iss_stall);

endmodule

// File: tb/tb_irf_wb_sched.sv
// Directed self-checking bench for irf_wb_sched (expectations follow IRF_WB_RR_EN).
module tb_irf_wb_sched;
  localparam int N_SRC = 3;
  localparam int AW    = 5;
  localparam int XW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_we;
  logic [AW-1:0] rd_addr;
  logic [XW-1:0] rd_data;
  logic          iss_valid, iss_rd_we, iss_fire, iss_stall;
  logic [AW-1:0] iss_rs1, iss_rs2, iss_rd;
  logic [31:0]   busy_vec;

  int n_checks = 0;
  int n_errors = 0;

  irf_wb_sched_if #(.N_SRC(N_SRC), .ADDR_W(AW), .XLEN(XW)) wb_if ();

  irf_wb_sched #(.addr_width(AW), .XLEN(XW), .N_SRC(N_SRC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb          (wb_if.slave),
    .o_rd_we     (rd_we),
    .o_rd_addr   (rd_addr),
    .o_rd_data   (rd_data),
    .i_iss_valid (iss_valid),
    .i_iss_rs1   (iss_rs1),
    .i_iss_rs2   (iss_rs2),
    .i_iss_rd    (iss_rd),
    .i_iss_rd_we (iss_rd_we),
    .i_iss_fire  (iss_fire),
    .o_iss_stall (iss_stall),
    .o_busy_vec  (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [AW-1:0] a, input logic [XW-1:0] d);
    wb_if.wb_valid[i]          = v;
    wb_if.wb_addr[i*AW +: AW]  = a;
    wb_if.wb_data[i*XW +: XW]  = d;
  endtask

  task automatic issue(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic rd_w, input logic fire);
    iss_valid = v; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_rd_we = rd_w; iss_fire = fire;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] exp_gnt [4];
`ifdef IRF_WB_RR_EN
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
    exp_gnt = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    wb_if.wb_valid = '0; wb_if.wb_addr = '0; wb_if.wb_data = '0;
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // 1. Reset (with requests pending, ready must stay low) then idle.
    rst_n = 1'b0;
    wb_if.wb_valid = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", wb_if.wb_ready, 3'b000);
    check("rst_rd_we", rd_we, 1'b0);
    check("rst_rd_addr", rd_addr, 5'd0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_busy", busy_vec, 32'h0);
    wb_if.wb_valid = '0;
    rst_n = 1'b1;
    issue(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0);
    step();
    check("idle_rd_we", rd_we, 1'b0);
    check("idle_ready", wb_if.wb_ready, 3'b000);
    check("idle_stall", iss_stall, 1'b0);
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // 2. Single write from source 1.
    set_src(1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check("single_ready", wb_if.wb_ready, 3'b010);
    step();
    set_src(1, 1'b0, 5'd0, 32'h0);
    #1;
    check("single_we", rd_we, 1'b1);
    check("single_addr", rd_addr, 5'd5);
    check("single_data", rd_data, 32'hDEADBEEF);
    step();
    check("single_we_drop", rd_we, 1'b0);
    check("single_addr_hold", rd_addr, 5'd5);

    // 3. Contention: fresh reset so the round-robin pointer starts at 0.
    do_reset();
    for (int i = 0; i < N_SRC; i++) set_src(i, 1'b1, AW'(i + 1), 32'hA000_0000 + i);
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("cont_gnt%0d", c), wb_if.wb_ready, exp_gnt[c]);
      step();
      for (int s = 0; s < N_SRC; s++)
        if (exp_gnt[c][s]) begin
          check($sformatf("cont_addr%0d", c), rd_addr, AW'(s + 1));
          check($sformatf("cont_data%0d", c), rd_data, 32'hA000_0000 + s);
        end
    end
    set_src(0, 1'b0, 5'd1, 32'hA000_0000);
    #1;
    check("cont_drop0", wb_if.wb_ready, 3'b010);
    step();
    set_src(1, 1'b0, 5'd2, 32'hA000_0001);
    #1;
    check("cont_drop1", wb_if.wb_ready, 3'b100);
    step();
    set_src(2, 1'b0, 5'd3, 32'hA000_0002);
    step();
    step();

    // 4. RAW/WAW hazard on x7.
    issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    #1;
    check("raw_pre_stall", iss_stall, 1'b0);
    iss_fire = 1'b1;
    step();
    issue(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("raw_busy7", busy_vec[7], 1'b1);
    check("raw_stall", iss_stall, 1'b1);
    issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    #1;
    check("waw_stall", iss_stall, 1'b1);
    issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("x0_no_stall", iss_stall, 1'b0);
    issue(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    check("raw_stall_hold", iss_stall, 1'b1);
    set_src(0, 1'b1, 5'd7, 32'h0000_0777);
    #1;
    check("raw_wb_ready", wb_if.wb_ready, 3'b001);
    check("raw_stall_hs", iss_stall, 1'b1);
    step();
    set_src(0, 1'b0, 5'd0, 32'h0);
    #1;
    check("raw_rd_we", rd_we, 1'b1);
    check("raw_rd_addr", rd_addr, 5'd7);
    check("raw_no_fwd", iss_stall, 1'b1);
    step();
    check("raw_release", iss_stall, 1'b0);
    check("raw_busy_clr", busy_vec, 32'h0);
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // 5. Set and clear of x9 at the same edge: set wins.
    set_src(2, 1'b1, 5'd9, 32'h0000_0999);
    step();
    set_src(2, 1'b0, 5'd0, 32'h0);
    issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
    #1;
    check("sc_rd_we", rd_we, 1'b1);
    check("sc_rd_addr", rd_addr, 5'd9);
    check("sc_stall", iss_stall, 1'b0);
    step();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("sc_busy", busy_vec, 32'h0000_0200);

    // 6a. x0 write: handshake happens, IRF write does not.
    set_src(0, 1'b1, 5'd0, 32'h0000_1234);
    #1;
    check("x0_ready", wb_if.wb_ready, 3'b001);
    step();
    set_src(0, 1'b0, 5'd0, 32'h0);
    #1;
    check("x0_rd_we", rd_we, 1'b0);
    check("x0_busy", busy_vec, 32'h0000_0200);

    // 6b. Reset mid-operation with x3 busy and a grant in flight.
    issue(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
    step();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    set_src(1, 1'b1, 5'd4, 32'h0000_0444);
    step();
    check("mid_pre_busy", busy_vec, 32'h0000_0208);
    check("mid_pre_we", rd_we, 1'b1);
    check("mid_pre_ready", wb_if.wb_ready, 3'b010);
    rst_n = 1'b0;
    #1;
    check("mid_busy", busy_vec, 32'h0);
    check("mid_rd_we", rd_we, 1'b0);
    check("mid_rd_addr", rd_addr, 5'd0);
    check("mid_ready", wb_if.wb_ready, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/irf_wb_sched.md
Name: irf_wb_sched

Overview:
- Write-back scheduler and scoreboard in front of the integer register file (IRF).
- Arbitrates N_SRC write-back requesters (ALU, LSU, MUL/DIV, ...) onto the IRF's single write port (rd_we/rd_addr/rd_data) using a valid/ready handshake.
- Tracks in-flight destination registers and tells issue when an instruction must stall on a RAW or WAW hazard.
- Sits between execute units/issue and the IRF.

Parameters:
- addr_width, 5, register address width; the IRF has 2**addr_width entries, and x0 is hardwired zero.
- XLEN, 32, data width.
- N_SRC, 3, number of write-back requesters (2..8).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_valid  in  N_SRC  per-source write-back request.
- wb_ready  out  N_SRC  per-source grant; a transfer happens when valid&ready.
- wb_addr  in  N_SRC*addr_width  packed destination addresses; source i occupies [i*addr_width +: addr_width].
- wb_data  in  N_SRC*XLEN  packed write data; source i occupies [i*XLEN +: XLEN].
- rd_we  out  1  IRF write enable (registered).
- rd_addr  out  addr_width  IRF write address (registered).
- rd_data  out  XLEN  IRF write data (registered).
- iss_valid  in  1  issue stage presents an instruction.
- iss_rs1, iss_rs2, iss_rd  in  addr_width each  issuing instruction's source and destination registers.
- iss_rd_we  in  1  the issuing instruction writes rd.
- iss_fire  in  1  the instruction actually issues this cycle; only legal when iss_stall=0.
- iss_stall  out  1  combinational hazard indication.
- busy_vec  out  2**addr_width  scoreboard state, for debug/verification.

Behaviour:
- Reset, asynchronous on rst_n low:
  - rd_we=0, rd_addr=0, rd_data=0.
  - Scoreboard all 0.
  - Round-robin pointer = 0.
  - wb_ready=0 while in reset.
  - In-flight grants are discarded, and the scoreboard is cleared even if units still hold results. Units must be reset together.
- Arbitration (combinational):
  - At most one wb_ready bit is high per cycle (one-hot or zero).
  - A source is granted only while its wb_valid is high.
  - The write port never back-pressures, so some valid source is always granted when any wb_valid is high.
  - Sources must hold valid, addr and data stable until ready.
- Write stage (1-cycle latency):
  - At the edge following a grant to source i: rd_we=1 iff wb_addr_i != 0; rd_addr=wb_addr_i; rd_data=wb_data_i.
  - With no grant: rd_we=0; rd_addr and rd_data hold their previous values.
  - The IRF write therefore lands at the second edge after the handshake.
- x0 writes: granted and acked normally, but rd_we stays 0 and the scoreboard is untouched.
- Scoreboard, one bit per register (bit 0 is constant 0):
  - Set: on iss_fire & iss_rd_we & iss_rd!=0.
  - Clear: on rd_we & rd_addr, at the same edge the IRF commits, so reads in the next cycle see the new value.
  - Set and clear of the same register in the same cycle: set wins (bit stays 1).
- Stall:
  - iss_stall = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | (iss_rd_we & busy[iss_rd])).
  - x0 never stalls.
  - No forwarding: a register whose write is in the rd_we cycle still reads as busy that cycle.
- Errors: iss_fire while iss_stall=1 is illegal and is checked by an assertion only; the RTL need not handle it.

Optional Feature:
- Macro: IRF_WB_RR_EN.
- Defined (round-robin arbitration):
  - Search starts at the pointer index and wraps modulo N_SRC.
  - After a grant to source i, pointer = (i+1) mod N_SRC.
  - The pointer is unchanged on idle cycles.
- Undefined (fixed priority):
  - Lowest index wins; no pointer register exists.
  - Starvation of high indices is permitted.

Decomposition:
- Package irf_pkg holds ADDR_W=5, XLEN=32, NREGS=1<<ADDR_W, and a typedef reg_addr_t.
- One sub-module, irf_wb_arb: N_SRC-wide arbiter with the pointer state under IRF_WB_RR_EN; outputs a one-hot grant plus a binary grant index.
- Write stage, scoreboard and stall logic live in irf_wb_sched.

Test Plan:
1. Reset then idle:
   - Stimulus: rst_n low for 3 cycles, then released with no requests.
   - Expected: rd_we=0, busy_vec=0, wb_ready=0, iss_stall=0.
2. Single write:
   - Stimulus: source 1 requests addr=5, data=0xDEADBEEF for 1 cycle.
   - Expected: wb_ready=3'b010 that cycle; next cycle rd_we=1, rd_addr=5, rd_data=0xDEADBEEF; following cycle rd_we=0.
3. Contention:
   - Stimulus: all 3 sources hold valid for 4 cycles.
   - Expected with RR: grant order 0,1,2,0.
   - Expected without RR: grant order 0,0,0,0, and source 0 must drop valid for 1 and 2 to be served.
4. Scoreboard RAW hazard:
   - Stimulus: fire with rd=7; then present rs1=7.
   - Expected: iss_stall=1 until the cycle after rd_we with rd_addr=7, then 0.
   - Stimulus: rs2=0.
   - Expected: never stalls.
5. Simultaneous set/clear:
   - Stimulus: rd_we for x9 in the same cycle as iss_fire with rd=9.
   - Expected: busy[9] remains 1 afterwards.
6. x0 write and mid-operation reset:
   - Stimulus: a grant with wb_addr=0.
   - Expected: ready asserted, rd_we stays 0.
   - Stimulus: assert rst_n with busy[3]=1 and a pending grant.
   - Expected: busy_vec=0 and rd_we=0 immediately, with no clock edge needed.
